// File: rtl/ssd_arbiter.sv
// ssd_arbiter: shares one 8-digit seven-segment display among four requesters.
// Round-robin grant among pending requests. A granted value stays on the display
// for at least HOLD_CYCLES cycles. The current owner may refresh its value at any
// time without restarting the hold. While lock is high the current owner keeps
// the display.
//
// Handshake: a requester raises req[i] with value_i and keeps both stable until
// ack[i] arrives. ack[i] is a one-cycle registered pulse. It is high in the cycle
// after the edge that latched value_i into number. If req[i] drops before the
// ack, the request is withdrawn and no ack is issued for it.
module ssd_arbiter #(
  parameter int HOLD_CYCLES = 50000000,
  parameter int CNT_WIDTH   = 26
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [3:0]  req,
  input  logic [31:0] value0,
  input  logic [31:0] value1,
  input  logic [31:0] value2,
  input  logic [31:0] value3,
  input  logic        lock,
  output logic [3:0]  ack,
  output logic [31:0] number,
  output logic [1:0]  source,
  output logic        valid,
  output logic        hold_active
);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  // Hold reload value; out-of-range HOLD_CYCLES is a configuration error.
  localparam logic [CNT_WIDTH-1:0] LOAD = CNT_WIDTH'(HOLD_CYCLES - 1);

  state_t               state, state_nx;
  logic [CNT_WIDTH-1:0] cnt, cnt_nx;
  logic [1:0]           ptr, ptr_nx, win, src_nx;
  logic                 found, grant, refresh, valid_nx;
  logic [3:0]           ack_nx, rot;
  logic [31:0]          num_nx;
  logic [31:0]          vals [4];

  // Collect requester values so they can be indexed by owner or winner.
  always_comb begin
    vals[0] = value0;
    vals[1] = value1;
    vals[2] = value2;
    vals[3] = value3;
  end

  // Round-robin pick: rotate req so the pointer sits at bit 0.
  // Then take the lowest set bit.
  always_comb begin
    rot   = 4'({req, req} >> ptr);
    found = 1'b0;
    win   = ptr;
    for (int k = 3; k >= 0; k--) begin
      if (rot[k]) begin
        found = 1'b1;
        win   = ptr + 2'(k);
      end
    end
  end

  // Next-state logic: a new grant in IDLE has priority over an owner refresh.
  // The hold counter only runs in HOLD, and only while lock is low.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    ptr_nx   = ptr;
    num_nx   = number;
    src_nx   = source;
    valid_nx = valid;
    ack_nx   = 4'b0000;
    grant    = (state == IDLE) && found && !lock;
    refresh  = !grant && valid && req[source];

    if (grant) begin
      num_nx      = vals[win];
      src_nx      = win;
      valid_nx    = 1'b1;
      ptr_nx      = win + 2'd1;
      cnt_nx      = LOAD;
      // A one-cycle hold leaves the arbiter free to grant again on the next edge.
      state_nx    = (LOAD != '0) ? HOLD : IDLE;
      ack_nx[win] = 1'b1;
    end else begin
      if (refresh) begin
        num_nx         = vals[source];
        ack_nx[source] = 1'b1;
      end
      if (state == HOLD && !lock) begin
        cnt_nx = (cnt != '0) ? cnt - CNT_WIDTH'(1) : '0;
        if (cnt <= CNT_WIDTH'(1)) state_nx = IDLE;
      end
    end
  end

  // State, counter, pointer and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      cnt    <= '0;
      ptr    <= 2'd0;
      number <= 32'd0;
      source <= 2'd0;
      valid  <= 1'b0;
      ack    <= 4'b0000;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      ptr    <= ptr_nx;
      number <= num_nx;
      source <= src_nx;
      valid  <= valid_nx;
      ack    <= ack_nx;
    end
  end

  assign hold_active = (cnt != '0);

endmodule

// File: tb/tb_ssd_arbiter.sv
// Directed bench for ssd_arbiter. Three instances share the same stimulus.
// They use hold lengths of 4, 8 and 1 cycles. Each step checks the instance it targets.
module tb_ssd_arbiter;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  req = 4'b0000;
  logic [31:0] value0 = '0, value1 = '0, value2 = '0, value3 = '0;
  logic        lock = 1'b0;

  logic [3:0]  ack4, ack8, ack1;
  logic [31:0] num4, num8, num1;
  logic [1:0]  src4, src8, src1;
  logic        val4, val8, val1;
  logic        ha4, ha8, ha1;

  int checks   = 0;
  int failures = 0;

  ssd_arbiter #(.HOLD_CYCLES(4), .CNT_WIDTH(8)) u4 (
    .clock(clock), .reset_n(reset_n), .req(req),
    .value0(value0), .value1(value1), .value2(value2), .value3(value3),
    .lock(lock), .ack(ack4), .number(num4), .source(src4),
    .valid(val4), .hold_active(ha4));

  ssd_arbiter #(.HOLD_CYCLES(8), .CNT_WIDTH(8)) u8 (
    .clock(clock), .reset_n(reset_n), .req(req),
    .value0(value0), .value1(value1), .value2(value2), .value3(value3),
    .lock(lock), .ack(ack8), .number(num8), .source(src8),
    .valid(val8), .hold_active(ha8));

  ssd_arbiter #(.HOLD_CYCLES(1), .CNT_WIDTH(8)) u1 (
    .clock(clock), .reset_n(reset_n), .req(req),
    .value0(value0), .value1(value1), .value2(value2), .value3(value3),
    .lock(lock), .ack(ack1), .number(num1), .source(src1),
    .valid(val1), .hold_active(ha1));

  // Clock generation.
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle 1 time unit past it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req     = 4'b0000;
    lock    = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    // Reset state, idle with no requests.
    do_reset();
    for (int i = 0; i < 10; i++) tick();
    chk("rst_number", num4, 32'd0);
    chk("rst_valid", {31'd0, val4}, 32'd0);
    chk("rst_ack", {28'd0, ack4}, 32'd0);
    chk("rst_source", {30'd0, src4}, 32'd0);
    chk("rst_hold", {31'd0, ha4}, 32'd0);

    // Single grant to requester 2 with a 4-cycle hold.
    value2 = 32'd123;
    req    = 4'b0100;
    tick();
    chk("g2_number", num4, 32'd123);
    chk("g2_source", {30'd0, src4}, 32'd2);
    chk("g2_valid", {31'd0, val4}, 32'd1);
    chk("g2_ack", {28'd0, ack4}, 32'b0100);
    chk("g2_hold0", {31'd0, ha4}, 32'd1);
    req = 4'b0000;
    tick();
    chk("g2_ack_gone", {28'd0, ack4}, 32'd0);
    chk("g2_hold1", {31'd0, ha4}, 32'd1);
    tick();
    chk("g2_hold2", {31'd0, ha4}, 32'd1);
    tick();
    chk("g2_hold3_off", {31'd0, ha4}, 32'd0);
    chk("g2_number_kept", num4, 32'd123);

    // Asynchronous reset in the middle of a hold.
    // The pointer is at 3, so requester 0 wins.
    value0 = 32'd77;
    req    = 4'b0001;
    tick();
    chk("g0_number", num4, 32'd77);
    req = 4'b0000;
    #2 reset_n = 1'b0;
    #1;
    chk("async_number", num4, 32'd0);
    chk("async_valid", {31'd0, val4}, 32'd0);
    chk("async_source", {30'd0, src4}, 32'd0);
    chk("async_ack", {28'd0, ack4}, 32'd0);
    chk("async_hold", {31'd0, ha4}, 32'd0);
    reset_n = 1'b1;

    // All four requesting continuously.
    // The expected grant order is 0,1,2,3,0, each held 4 cycles with owner refresh acks.
    do_reset();
    value0 = 32'd10;
    value1 = 32'd11;
    value2 = 32'd12;
    value3 = 32'd13;
    req    = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      for (int c = 0; c < 4; c++) begin
        tick();
        chk($sformatf("rr_src_g%0d_c%0d", g, c), {30'd0, src4}, 32'(g % 4));
        chk($sformatf("rr_num_g%0d_c%0d", g, c), num4, 32'(10 + g % 4));
        chk($sformatf("rr_ack_g%0d_c%0d", g, c), {28'd0, ack4}, 32'(1 << (g % 4)));
        chk($sformatf("rr_onehot_g%0d_c%0d", g, c), {31'd0, $onehot0(ack4)}, 32'd1);
        if (g == 4) break;
      end
    end

    // 8-cycle hold. Requester 0 refreshes its value during the hold.
    // Requester 3 waits and takes over after the hold expires.
    do_reset();
    value0 = 32'd5;
    value3 = 32'd99;
    req    = 4'b0001;
    tick();
    chk("own_num5", num8, 32'd5);
    chk("own_ack5", {28'd0, ack8}, 32'b0001);
    value0 = 32'd6;
    tick();
    chk("own_num6", num8, 32'd6);
    chk("own_ack6", {28'd0, ack8}, 32'b0001);
    value0 = 32'd7;
    req    = 4'b1001;
    tick();
    chk("own_num7", num8, 32'd7);
    chk("own_ack7", {28'd0, ack8}, 32'b0001);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk($sformatf("own_wait_ack_c%0d", c), {28'd0, ack8}, 32'b0001);
      chk($sformatf("own_wait_src_c%0d", c), {30'd0, src8}, 32'd0);
    end
    tick();
    chk("own_take_src", {30'd0, src8}, 32'd3);
    chk("own_take_ack", {28'd0, ack8}, 32'b1000);
    chk("own_take_num", num8, 32'd99);

    // Lock freezes the hold while requester 1 owns the display.
    // Requester 2 stays pending until the lock is released.
    do_reset();
    value1 = 32'd21;
    value2 = 32'd22;
    req    = 4'b0010;
    tick();
    chk("lk_grant_src", {30'd0, src4}, 32'd1);
    chk("lk_grant_num", num4, 32'd21);
    req  = 4'b0100;
    lock = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      chk($sformatf("lk_src_c%0d", c), {30'd0, src4}, 32'd1);
      chk($sformatf("lk_ack_c%0d", c), {28'd0, ack4}, 32'd0);
    end
    chk("lk_hold_frozen", {31'd0, ha4}, 32'd1);
    lock = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("lk_rel_src_c%0d", c), {30'd0, src4}, 32'd1);
      chk($sformatf("lk_rel_ack_c%0d", c), {28'd0, ack4}, 32'd0);
    end
    tick();
    chk("lk_after_src", {30'd0, src4}, 32'd2);
    chk("lk_after_ack", {28'd0, ack4}, 32'b0100);
    chk("lk_after_num", num4, 32'd22);

    // One-cycle hold: a grant on every edge as req alternates.
    do_reset();
    value0 = 32'd31;
    value1 = 32'd32;
    for (int c = 0; c < 5; c++) begin
      req = (c % 2 == 0) ? 4'b0001 : 4'b0010;
      tick();
      chk($sformatf("h1_src_c%0d", c), {30'd0, src1}, 32'(c % 2));
      chk($sformatf("h1_ack_c%0d", c), {28'd0, ack1}, (c % 2 == 0) ? 32'b0001 : 32'b0010);
      chk($sformatf("h1_num_c%0d", c), num1, (c % 2 == 0) ? 32'd31 : 32'd32);
    end
    chk("h1_hold_off", {31'd0, ha1}, 32'd0);
    // Requester 1 is blocked by lock, then withdraws before it is ever granted.
    lock = 1'b1;
    req  = 4'b0010;
    tick();
    chk("wd_locked_ack", {28'd0, ack1}, 32'd0);
    chk("wd_locked_src", {30'd0, src1}, 32'd0);
    req  = 4'b0000;
    lock = 1'b0;
    tick();
    chk("wd_ack0", {28'd0, ack1}, 32'd0);
    tick();
    chk("wd_ack1", {28'd0, ack1}, 32'd0);
    chk("wd_src", {30'd0, src1}, 32'd0);
    chk("wd_num", num1, 32'd31);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
